// File: rtl/backend_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// backend_seq : AFE backend startup sequencer (serial gain load, VCO/amp reset
//               release, VCO frequency comparison).            Rev 1.0
// ----------------------------------------------------------------------------
module backend_seq #(
  parameter int NCH    = 2,
  parameter int GW     = 3,
  parameter int CNT_W  = 8,
  parameter int T_VCO  = 20,
  parameter int T_MEAS = 64
) (
  input  logic              i_clk,
  input  logic              i_resetbAll,
  input  logic              i_sclk,
  input  logic              i_sdin,
  input  logic              i_clk_vco1,
  input  logic              i_clk_vco2,
  input  logic              i_restart,
  output logic [NCH*GW-1:0] o_gain,
  output logic [NCH-1:0]    o_resetb,
  output logic              o_resetbvco1,
  output logic              o_resetbvco2,
  output logic              o_vco1_fast,
  output logic              o_ready,
  output logic              o_busy
);

  localparam int NW    = NCH * GW;
  localparam int TMAX0 = (T_VCO > T_MEAS) ? T_VCO : T_MEAS;
  localparam int TMAX  = (TMAX0 > 4) ? TMAX0 : 4;
  localparam int TW    = $clog2(TMAX + 1);
  localparam int BW    = $clog2(NW + 1);

  typedef enum logic [2:0] {
    S_SHIFT    = 3'd0,
    S_SETTLE   = 3'd1,
    S_VCO_EN   = 3'd2,
    S_VCO_WAIT = 3'd3,
    S_AMP_EN   = 3'd4,
    S_MEAS     = 3'd5,
    S_CMP      = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  // Bit 3 (sdin) is synchronised alongside sclk so data and strobe stay aligned.
  logic [3:0] async_in;
  logic [3:0] meta_q;
  logic [3:0] sync_q;
  logic [2:0] prev_q;
  logic [2:0] rise;
  logic       sclk_rise;
  logic       vco1_rise;
  logic       vco2_rise;
  logic       sdin_s;

  assign async_in  = {i_sdin, i_clk_vco2, i_clk_vco1, i_sclk};
  assign rise      = sync_q[2:0] & ~prev_q;
  assign sclk_rise = rise[0];
  assign vco1_rise = rise[1];
  assign vco2_rise = rise[2];
  assign sdin_s    = sync_q[3];

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q[2:0];
    end
  end

  state_t           state_q,   state_d;
  logic [BW-1:0]    bitcnt_q,  bitcnt_d;
  logic [NW-1:0]    shreg_q,   shreg_d;
  logic [TW-1:0]    tmr_q,     tmr_d;
  logic [CNT_W-1:0] cnt1_q,    cnt1_d;
  logic [CNT_W-1:0] cnt2_q,    cnt2_d;
  logic [NW-1:0]    gain_q,    gain_d;
  logic [NCH-1:0]   rstb_q,    rstb_d;
  logic             vcorstb_q, vcorstb_d;
  logic             fast_q,    fast_d;
  logic             ready_q,   ready_d;
  logic             busy_q,    busy_d;

  always_ff @(posedge i_clk or negedge i_resetbAll) begin
    if (!i_resetbAll) begin
      state_q   <= S_SHIFT;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      tmr_q     <= '0;
      cnt1_q    <= '0;
      cnt2_q    <= '0;
      gain_q    <= '0;
      rstb_q    <= '0;
      vcorstb_q <= 1'b0;
      fast_q    <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      tmr_q     <= tmr_d;
      cnt1_q    <= cnt1_d;
      cnt2_q    <= cnt2_d;
      gain_q    <= gain_d;
      rstb_q    <= rstb_d;
      vcorstb_q <= vcorstb_d;
      fast_q    <= fast_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    tmr_d     = tmr_q;
    cnt1_d    = cnt1_q;
    cnt2_d    = cnt2_q;
    gain_d    = gain_q;
    rstb_d    = rstb_q;
    vcorstb_d = vcorstb_q;
    fast_d    = fast_q;
    ready_d   = 1'b0;
    busy_d    = 1'b1;

    unique case (state_q)
      S_SHIFT: begin
        if (sclk_rise) begin
          shreg_d = (shreg_q << 1) | NW'(sdin_s);
          if (bitcnt_q == BW'(NW - 1)) begin
            bitcnt_d = '0;
            tmr_d    = '0;
            state_d  = S_SETTLE;
          end else begin
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
      end

      S_SETTLE: begin
        if (tmr_q == TW'(3)) begin
          tmr_d   = '0;
          gain_d  = shreg_q;
          state_d = S_VCO_EN;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_VCO_EN: begin
        vcorstb_d = 1'b1;
        tmr_d     = '0;
        state_d   = S_VCO_WAIT;
      end

      S_VCO_WAIT: begin
        if (tmr_q == TW'(T_VCO - 1)) begin
          tmr_d   = '0;
          state_d = S_AMP_EN;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_AMP_EN: begin
        rstb_d  = '1;
        cnt1_d  = '0;
        cnt2_d  = '0;
        tmr_d   = '0;
        state_d = S_MEAS;
      end

      S_MEAS: begin
        // Counters stick at all-ones so a very fast VCO cannot wrap to a small value.
        if (vco1_rise && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
        if (vco2_rise && (cnt2_q != '1)) cnt2_d = cnt2_q + CNT_W'(1);
        if (tmr_q == TW'(T_MEAS - 1)) begin
          tmr_d   = '0;
          state_d = S_CMP;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end

      S_CMP: begin
        fast_d  = (cnt1_q > cnt2_q);
        state_d = S_DONE;
      end

      S_DONE: begin
        if (i_restart) begin
          state_d   = S_SHIFT;
          bitcnt_d  = '0;
          rstb_d    = '0;
          vcorstb_d = 1'b0;
        end else begin
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end
      end

      default: state_d = S_SHIFT;
    endcase
  end

  assign o_gain       = gain_q;
  assign o_resetb     = rstb_q;
  assign o_resetbvco1 = vcorstb_q;
  assign o_resetbvco2 = vcorstb_q;
  assign o_vco1_fast  = fast_q;
  assign o_ready      = ready_q;
  assign o_busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_backend_seq.sv
`default_nettype none
// tb_backend_seq: directed, table-driven checks of backend_seq on three
// parameter sets (default, CNT_W=4, NCH=4/GW=2/T_VCO=3/T_MEAS=8).
module tb_backend_seq;

  logic clk     = 1'b0;
  logic rstb    = 1'b0;
  logic sclk    = 1'b0;
  logic sdin    = 1'b0;
  logic vco1    = 1'b0;
  logic vco2    = 1'b0;
  logic restart = 1'b0;

  always #5 clk = ~clk;

  logic [5:0] a_gain; logic [1:0] a_rstb; logic a_v1, a_v2, a_fast, a_ready, a_busy;
  logic [5:0] s_gain; logic [1:0] s_rstb; logic s_v1, s_v2, s_fast, s_ready, s_busy;
  logic [7:0] b_gain; logic [3:0] b_rstb; logic b_v1, b_v2, b_fast, b_ready, b_busy;

  backend_seq dut_a (
    .i_clk(clk), .i_resetbAll(rstb), .i_sclk(sclk), .i_sdin(sdin),
    .i_clk_vco1(vco1), .i_clk_vco2(vco2), .i_restart(restart),
    .o_gain(a_gain), .o_resetb(a_rstb), .o_resetbvco1(a_v1), .o_resetbvco2(a_v2),
    .o_vco1_fast(a_fast), .o_ready(a_ready), .o_busy(a_busy)
  );

  backend_seq #(.CNT_W(4)) dut_s (
    .i_clk(clk), .i_resetbAll(rstb), .i_sclk(sclk), .i_sdin(sdin),
    .i_clk_vco1(vco1), .i_clk_vco2(vco2), .i_restart(restart),
    .o_gain(s_gain), .o_resetb(s_rstb), .o_resetbvco1(s_v1), .o_resetbvco2(s_v2),
    .o_vco1_fast(s_fast), .o_ready(s_ready), .o_busy(s_busy)
  );

  backend_seq #(.NCH(4), .GW(2), .T_VCO(3), .T_MEAS(8)) dut_b (
    .i_clk(clk), .i_resetbAll(rstb), .i_sclk(sclk), .i_sdin(sdin),
    .i_clk_vco1(vco1), .i_clk_vco2(vco2), .i_restart(restart),
    .o_gain(b_gain), .o_resetb(b_rstb), .o_resetbvco1(b_v1), .o_resetbvco2(b_v2),
    .o_vco1_fast(b_fast), .o_ready(b_ready), .o_busy(b_busy)
  );

  // VCO waveforms derived from one cycle counter; equal periods give equal phase.
  int cyc = 0;
  int p1  = 0;
  int p2  = 0;
  always @(negedge clk) begin
    cyc  = cyc + 1;
    vco1 = (p1 != 0) && ((cyc % p1) < (p1 / 2));
    vco2 = (p2 != 0) && ((cyc % p2) < (p2 / 2));
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sclk = 1'b0; sdin = 1'b0; restart = 1'b0; rstb = 1'b0;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
  endtask

  // MSB first; sclk period 8 clk, data set up 3 clk before the rising edge.
  task automatic send_bits(input logic [7:0] f, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      sdin = f[i];
      sclk = 1'b0;
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      if (i > 0) repeat (4) @(negedge clk);
    end
  endtask

  // Returns just after edge L (third i_clk edge after the last sclk rise).
  task automatic to_capture();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pulse_restart();
    @(negedge clk);
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
  endtask

  typedef struct {
    logic [5:0] frame;
    int         vp1;
    int         vp2;
    logic [5:0] gain;
    logic       fast;
  } vec_t;

  vec_t vecs[4];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{frame: 6'b010110, vp1: 10, vp2: 5,  gain: 6'b010110, fast: 1'b0};
    vecs[1] = '{frame: 6'b111000, vp1: 6,  vp2: 6,  gain: 6'b111000, fast: 1'b0};
    vecs[2] = '{frame: 6'b000001, vp1: 7,  vp2: 0,  gain: 6'b000001, fast: 1'b1};
    vecs[3] = '{frame: 6'b101011, vp1: 5,  vp2: 10, gain: 6'b101011, fast: 1'b1};

    do_reset();
    #1;
    chk("rst_gain",   a_gain,  0);
    chk("rst_resetb", a_rstb,  0);
    chk("rst_vco1",   a_v1,    0);
    chk("rst_vco2",   a_v2,    0);
    chk("rst_fast",   a_fast,  0);
    chk("rst_ready",  a_ready, 0);
    chk("rst_busy",   a_busy,  1);
    chk("rst_b_gain", b_gain,  0);

    // Full sequence timing, relative to capture edge L.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      p1 = vecs[v].vp1;
      p2 = vecs[v].vp2;
      send_bits({2'b00, vecs[v].frame}, 6);
      to_capture();
      adv(3);  chk($sformatf("v%0d_gain_L3", v),   a_gain, 0);
      adv(1);  chk($sformatf("v%0d_gain_L4", v),   a_gain, vecs[v].gain);
               chk($sformatf("v%0d_vco_L4", v),    a_v1,   0);
      adv(1);  chk($sformatf("v%0d_vco1_L5", v),   a_v1,   1);
               chk($sformatf("v%0d_vco2_L5", v),   a_v2,   1);
      adv(20); chk($sformatf("v%0d_rstb_L25", v),  a_rstb, 0);
      adv(1);  chk($sformatf("v%0d_rstb_L26", v),  a_rstb, 2'b11);
      adv(65); chk($sformatf("v%0d_fast_L91", v),  a_fast, vecs[v].fast);
               chk($sformatf("v%0d_ready_L91", v), a_ready, 0);
               chk($sformatf("v%0d_busy_L91", v),  a_busy, 1);
      adv(1);  chk($sformatf("v%0d_ready_L92", v), a_ready, 1);
               chk($sformatf("v%0d_busy_L92", v),  a_busy, 0);
    end

    // Restart from DONE: gain/fast held until reload.
    pulse_restart();
    chk("rs_ready", a_ready, 0);
    chk("rs_busy",  a_busy,  1);
    chk("rs_rstb",  a_rstb,  0);
    chk("rs_vco",   a_v1,    0);
    chk("rs_gain",  a_gain,  6'b101011);
    chk("rs_fast",  a_fast,  1);
    send_bits(8'b000111, 6);
    to_capture();
    adv(3);  chk("rs_gain_L3",  a_gain,  6'b101011);
    adv(1);  chk("rs_gain_L4",  a_gain,  6'b000111);
    adv(88); chk("rs_ready_L92", a_ready, 1);

    // Asynchronous reset in the middle of a frame.
    pulse_restart();
    send_bits(8'b110, 3);
    @(posedge clk);
    #3 rstb = 1'b0;
    #1;
    chk("mr_gain",  a_gain,  0);
    chk("mr_fast",  a_fast,  0);
    chk("mr_busy",  a_busy,  1);
    chk("mr_ready", a_ready, 0);
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    send_bits(8'b010010, 6);
    to_capture();
    adv(3); chk("mr_gain_L3", a_gain, 0);
    adv(1); chk("mr_gain_L4", a_gain, 6'b010010);

    // Saturation: 16 VCO1 edges in a 64-cycle window with a 4-bit counter.
    do_reset();
    p1 = 4;
    p2 = 0;
    send_bits(8'b101011, 6);
    to_capture();
    adv(91);
    chk("sat_fast", s_fast, 1);
    chk("sat_cnt1", dut_s.cnt1_q, 15);
    chk("sat_cnt2", dut_s.cnt2_q, 0);
    adv(1);
    chk("sat_ready", s_ready, 1);

    // Four 2-bit channels, short delays, restart ignored during MEAS.
    do_reset();
    p1 = 4;
    p2 = 0;
    send_bits(8'b10011100, 8);
    to_capture();
    adv(4); chk("b_gain_L4", b_gain, 8'b10011100);
            chk("b_ch3",     b_gain[7:6], 2'd2);
            chk("b_ch0",     b_gain[1:0], 2'd0);
            chk("b_vco_L4",  b_v1, 0);
    adv(1); chk("b_vco_L5",  b_v1, 1);
    adv(3); chk("b_rstb_L8", b_rstb, 4'b0000);
    adv(1); chk("b_rstb_L9", b_rstb, 4'b1111);
    restart = 1'b1;
    adv(1);
    restart = 1'b0;
    adv(7); chk("b_fast_L17",  b_fast, 0);
            chk("b_busy_L17",  b_busy, 1);
    adv(1); chk("b_fast_L18",  b_fast, 1);
            chk("b_ready_L18", b_ready, 0);
    adv(1); chk("b_ready_L19", b_ready, 1);
            chk("b_busy_L19",  b_busy, 0);
            chk("b_rstb_L19",  b_rstb, 4'b1111);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/backend_seq.md
# backend_seq

Parametrised startup sequencer for the analog front-end backend. It receives a serial gain-configuration frame for `NCH` amplifier channels and releases the VCO resets, then the amplifier resets, after programmable delays. It measures which of two VCOs runs faster by counting edges over a fixed window, then raises ready. It generalises the two-channel fixed-gain sequencer with the following additions:
- configurable channel count, gain width and delays
- synchronised serial and VCO inputs
- true frequency comparison
- a restart mode

## Interface
Parameters:
- `NCH`, 2, number of amplifier channels (1..8)
- `GW`, 3, gain bits per channel (1..4)
- `CNT_W`, 8, VCO edge-counter width
- `T_VCO`, 20, i_clk cycles between VCO reset release and amplifier reset release (≥1)
- `T_MEAS`, 64, measurement window in i_clk cycles (≥1)

Ports:
- `i_clk`  in  1  system clock
- `i_resetbAll`  in  1  reset, asynchronous, active-low
- `i_sclk`  in  1  serial config clock, asynchronous to i_clk, period ≥ 8 i_clk
- `i_sdin`  in  1  serial data, stable around i_sclk rising edge
- `i_clk_vco1`, `i_clk_vco2`  in  1  VCO clocks, frequency < i_clk/4
- `i_restart`  in  1  single-cycle pulse; rerun sequence from DONE
- `o_gain`  out  NCH*GW  gain words; channel c at [c*GW +: GW]
- `o_resetb`  out  NCH  per-channel amplifier reset, active-low
- `o_resetbvco1`, `o_resetbvco2`  out  1  VCO resets, active-low
- `o_vco1_fast`  out  1  1 = VCO1 counted strictly more edges than VCO2
- `o_ready`  out  1  sequence complete
- `o_busy`  out  1  high in every state except DONE

## Operation
- Frame length is `NCH*GW` bits, MSB first. The first bit received lands in bit `NCH*GW-1` of the shift register.
- `i_sclk`, `i_clk_vco1` and `i_clk_vco2` each pass through a 2-flop synchroniser followed by a rising-edge detector (registered previous value).
- States: SHIFT → SETTLE → VCO_EN → VCO_WAIT → AMP_EN → MEAS → CMP → DONE.
  - SHIFT: each detected i_sclk edge shifts in i_sdin and increments the bit counter. The capture of bit `NCH*GW` moves the FSM to SETTLE and clears the bit counter.
  - SETTLE: 4 cycles. On exit, o_gain loads from the shift register.
  - VCO_EN: 1 cycle. o_resetbvco1 and o_resetbvco2 are set to 1.
  - VCO_WAIT: `T_VCO` cycles.
  - AMP_EN: 1 cycle. o_resetb is set to all ones; both VCO counters clear.
  - MEAS: `T_MEAS` cycles. Each synchronised VCO edge increments its counter; counters saturate at `2^CNT_W-1`.
  - CMP: 1 cycle. o_vco1_fast is set to (cnt1 > cnt2). A tie gives 0.
  - DONE: o_ready = 1; the FSM holds.
- i_restart in DONE:
  - next state is SHIFT
  - o_ready, o_resetb and both VCO resets return to 0
  - o_gain and o_vco1_fast keep their values until reloaded
- i_restart in any other state is ignored.
- i_sclk edges outside SHIFT are ignored and do not disturb the shift register.
- All outputs are registered.

## Timing
- Reset values: o_gain=0, o_resetb=0, o_resetbvco1/2=0, o_vco1_fast=0, o_ready=0, o_busy=1, state=SHIFT, all counters 0.
- Reset asserted mid-sequence aborts immediately, asynchronously, to the reset values. A partial frame is discarded.
- An i_sclk rising edge is captured on the 3rd i_clk edge after it, with ±1 cycle of uncertainty from asynchronous phase.
- Relative to the i_clk edge that captures the last bit (cycle L):
  - o_gain updates after edge L+4
  - o_resetbvco rises after edge L+5
  - o_resetb rises `T_VCO+1` cycles after o_resetbvco
  - o_vco1_fast is valid `T_MEAS+1` cycles after o_resetb
  - o_ready rises 1 cycle after o_vco1_fast
- o_busy falls in the same cycle that o_ready rises.
- A restart pulse in DONE sets o_ready=0 on the next edge.
- Simultaneous i_restart and a VCO/sclk edge: restart takes priority; the edge is dropped.

## Test plan
- Default params; send 6-bit frame 101_011 (ch1=5, ch0=3) → o_gain=6'b101011 at L+4, o_resetbvco=1 at L+5, o_resetb=2'b11 at L+26, o_ready=1 after L+92.
- VCO1 = i_clk/5, VCO2 = i_clk/10 → o_vco1_fast=1. Swap the two → 0. Equal frequencies, same phase → 0.
- VCO1 faster than `2^CNT_W-1` edges per window (CNT_W=4) → counter saturates at 15, no wrap. VCO2 at 0 edges → o_vco1_fast=1.
- i_resetbAll low after 3 of 6 bits → all outputs at reset values. A fresh 6-bit frame afterwards loads correctly; no residual bits.
- In DONE pulse i_restart, send frame 000_111 → o_ready drops next cycle, resets go 0, o_gain holds 6'b101011 until reload, then becomes 6'b000111. o_ready returns.
- NCH=4, GW=2, T_VCO=3, T_MEAS=8 → 8-bit frame maps to four 2-bit gains. o_resetb=4'b1111 exactly 4 cycles after VCO release. i_restart pulsed during MEAS is ignored.
